// File: rtl/arbiter_hold_if.sv
// Request/grant bundle between bus masters and the hold arbiter.
// The arbiter sits on the slave modport; requesters use master.
interface arbiter_hold_if #(
    parameter int NUM_PORTS = 6,
    parameter int ID_WIDTH  = 3
);
    logic [NUM_PORTS-1:0] request;
    logic [NUM_PORTS-1:0] grant;
    logic [ID_WIDTH-1:0]  grant_id;
    logic                 active;
    logic                 preempt;

    modport master (
        output request,
        input  grant,
        input  grant_id,
        input  active,
        input  preempt
    );

    modport slave (
        input  request,
        output grant,
        output grant_id,
        output active,
        output preempt
    );
endinterface

// File: rtl/arbiter_hold.sv
// Round-robin arbiter with multi-cycle ownership; a contended owner is
// rotated out after MAX_HOLD granted cycles, with a one-cycle idle gap.
module arbiter_hold #(
    parameter int NUM_PORTS  = 6,
    parameter int MAX_HOLD   = 8,
    parameter int HOLD_WIDTH = 4,
    parameter int ID_WIDTH   = 3
) (
    input  logic          clk,
    input  logic          rst,
    arbiter_hold_if.slave arb
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);
    localparam logic [ID_WIDTH-1:0]   LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_PORTS-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic                  active_q;
    logic                  preempt_q, preempt_d;
    logic [HOLD_WIDTH-1:0] count_q, count_d;
    logic [ID_WIDTH-1:0]   last_q, last_d;

    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_id;
    logic [ID_WIDTH-1:0]   cand;
    logic                  owner_req;
    logic                  contended;

    // Search starts just past the previous owner, so it is served last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            cand = ID_WIDTH'((32'(last_q) + off) % NUM_PORTS);
            if (!win_found && arb.request[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign owner_req = arb.request[grant_id_q];
    assign contended = |(arb.request & ~grant_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        count_d    = count_q;
        last_d     = last_q;
        preempt_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d    = '0;
                grant_id_d = '0;
                if (win_found) begin
                    grant_d    = NUM_PORTS'(1) << win_id;
                    grant_id_d = win_id;
                    count_d    = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    last_d     = grant_id_q;
                    state_d    = IDLE;
                end else if (count_q == HOLD_LAST) begin
                    if (contended) begin
                        grant_d    = '0;
                        grant_id_d = '0;
                        last_d     = grant_id_q;
                        preempt_d  = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + HOLD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            active_q   <= 1'b0;
            preempt_q  <= 1'b0;
            count_q    <= '0;
            last_q     <= LAST_PORT;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            active_q   <= |grant_d;
            preempt_q  <= preempt_d;
            count_q    <= count_d;
            last_q     <= last_d;
        end
    end

    assign arb.grant    = grant_q;
    assign arb.grant_id = grant_id_q;
    assign arb.active   = active_q;
    assign arb.preempt  = preempt_q;

endmodule

// File: tb/tb_arbiter_hold.sv
// Drives two arbiters (hold limit 8 and 1) with directed then random requests
// and compares every cycle against an ownership-level reference model.
module tb_arbiter_hold;

    localparam int N = 6;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    arbiter_hold_if #(.NUM_PORTS(N), .ID_WIDTH(3)) bus8 ();
    arbiter_hold_if #(.NUM_PORTS(N), .ID_WIDTH(3)) bus1 ();

    arbiter_hold #(.NUM_PORTS(N), .MAX_HOLD(8), .HOLD_WIDTH(4), .ID_WIDTH(3))
        dut8 (.clk(clk), .rst(rst), .arb(bus8));
    arbiter_hold #(.NUM_PORTS(N), .MAX_HOLD(1), .HOLD_WIDTH(4), .ID_WIDTH(3))
        dut1 (.clk(clk), .rst(rst), .arb(bus1));

    // Model state per arbiter: owner (-1 = nobody), cycles granted so far,
    // previous owner, and whether the last edge was a hold-limit rotation.
    int owner [2];
    int gcnt  [2];
    int last  [2];
    bit pre   [2];
    int maxh  [2] = '{8, 1};

    task automatic model_update(input logic [N-1:0] r, input logic rv);
        for (int m = 0; m < 2; m++) begin
            if (rv) begin
                owner[m] = -1;
                gcnt[m]  = 0;
                last[m]  = N - 1;
                pre[m]   = 1'b0;
            end else begin
                pre[m] = 1'b0;
                if (owner[m] < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        int p;
                        p = (last[m] + k) % N;
                        if (owner[m] < 0 && r[p]) begin
                            owner[m] = p;
                            gcnt[m]  = 1;
                        end
                    end
                end else if (!r[owner[m]]) begin
                    last[m]  = owner[m];
                    owner[m] = -1;
                end else if (gcnt[m] == maxh[m]) begin
                    if ((r & ~(N'(1) << owner[m])) != '0) begin
                        pre[m]   = 1'b1;
                        last[m]  = owner[m];
                        owner[m] = -1;
                    end else begin
                        gcnt[m] = 1;
                    end
                end else begin
                    gcnt[m]++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg8, eg1;
        eg8 = (owner[0] < 0) ? '0 : N'(1) << owner[0];
        eg1 = (owner[1] < 0) ? '0 : N'(1) << owner[1];
        chk("grant8",    32'(bus8.grant),    32'(eg8));
        chk("grant_id8", 32'(bus8.grant_id), (owner[0] < 0) ? 32'd0 : 32'(owner[0]));
        chk("active8",   32'(bus8.active),   32'(owner[0] >= 0));
        chk("preempt8",  32'(bus8.preempt),  32'(pre[0]));
        chk("grant1",    32'(bus1.grant),    32'(eg1));
        chk("grant_id1", 32'(bus1.grant_id), (owner[1] < 0) ? 32'd0 : 32'(owner[1]));
        chk("active1",   32'(bus1.active),   32'(owner[1] >= 0));
        chk("preempt1",  32'(bus1.preempt),  32'(pre[1]));
    endtask

    task automatic step(input logic [N-1:0] r, input logic rv);
        @(negedge clk);
        check_all();
        rst          = rv;
        bus8.request = r;
        bus1.request = r;
        @(posedge clk);
        model_update(r, rv);
    endtask

    initial begin
        logic [N-1:0] rr;
        rst          = 1'b1;
        bus8.request = '0;
        bus1.request = '0;
        @(posedge clk);
        model_update('0, 1'b1);
        repeat (2) step('0, 1'b1);

        // Two steady requesters: alternating 8-cycle ownership with preempt.
        repeat (40) step(6'b000101, 1'b0);
        repeat (2)  step(6'b000000, 1'b0);

        // Lone requester holds well past the limit without preemption.
        repeat (20) step(6'b001000, 1'b0);
        repeat (3)  step(6'b000000, 1'b0);

        // Wrap-around order after port 5 was served.
        repeat (4)  step(6'b100000, 1'b0);
        repeat (2)  step(6'b000000, 1'b0);
        repeat (30) step(6'b100011, 1'b0);
        repeat (2)  step(6'b000000, 1'b0);

        // Port 2 drops on its 8th granted cycle while port 4 waits.
        step('0, 1'b1);
        step(6'b000100, 1'b0);
        repeat (7) step(6'b010100, 1'b0);
        step(6'b010000, 1'b0);
        repeat (4) step(6'b010000, 1'b0);

        // All ports requesting: strict rotation on the MAX_HOLD=1 instance.
        step('0, 1'b1);
        repeat (30) step(6'b111111, 1'b0);

        // Reset in the middle of an ownership, then contended restart.
        step('0, 1'b1);
        repeat (5)  step(6'b001000, 1'b0);
        step(6'b001000, 1'b1);
        repeat (4)  step(6'b001000, 1'b0);
        repeat (14) step(6'b001010, 1'b0);

        // Random request churn with occasional resets.
        rr = '0;
        repeat (1500) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) rr[i] = ~rr[i];
            step(rr, ($urandom_range(199) == 0));
        end
        step('0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbiter_hold.md
Name: arbiter_hold

Overview:
- Round-robin arbiter in which the winning requester keeps ownership of the shared resource across multiple cycles.
- Ownership ends when the owner drops its request, or is forcibly rotated after MAX_HOLD granted cycles if other ports are waiting.
- Sits between bus masters (DMA engines, stream writers) and a shared memory or bus port that needs multi-beat ownership. It replaces single-cycle token arbitration where a transfer must not be interleaved.

Parameters:
- NUM_PORTS, 6, number of requesting actors (at least 2).
- MAX_HOLD, 8, maximum consecutive granted cycles for one owner while other ports are requesting (1 to 2**HOLD_WIDTH).
- HOLD_WIDTH, 4, width of the hold counter.
- ID_WIDTH, 3, width of grant_id (at least clog2(NUM_PORTS)).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- request  input  NUM_PORTS  per-actor request; held high for the full duration of the desired ownership.
- grant  output  NUM_PORTS  registered one-hot grant, or all zero.
- grant_id  output  ID_WIDTH  registered binary index of the granted port; 0 when idle.
- active  output  1  registered; high exactly when grant is nonzero.
- preempt  output  1  registered one-cycle pulse; asserted on the edge where an owner's grant is removed by the hold limit.

Behaviour:
- Clock and reset: clk is the clock; rst is a synchronous, active-high reset.
- Reset values:
  - grant=0, grant_id=0, active=0, preempt=0.
  - state=IDLE, hold count=0.
  - last_owner=NUM_PORTS-1, so port 0 has highest priority after reset.
- States: IDLE (no owner) and OWN (one port granted).
- IDLE:
  - If request is nonzero, pick the first set bit searching last_owner+1, last_owner+2, ... with wrap-around modulo NUM_PORTS.
  - Next edge: grant=onehot(winner), grant_id=winner, active=1, count=0, state=OWN.
  - If request is zero, stay in IDLE with outputs at 0.
- IDLE latency: request sampled high in cycle t gives grant high in cycle t+1.
- OWN, evaluated every cycle in priority order:
  1. request[owner]==0: next edge grant=0, grant_id=0, active=0, last_owner=owner, state=IDLE, preempt=0.
  2. Else if count==MAX_HOLD-1 and (request & ~grant)!=0: next edge grant=0, grant_id=0, active=0, preempt=1, last_owner=owner, state=IDLE.
  3. Else if count==MAX_HOLD-1 with no other requester: count=0, grant held. An uncontended owner holds indefinitely.
  4. Else: count=count+1, grant held.
- Turnaround: after any release or preemption, grant is 0 for exactly one cycle. The next grant appears the cycle after, chosen by IDLE arbitration. Gap between consecutive owners = 1 idle cycle.
- Release timing: when an owner drops its request at cycle t, its grant is still high in cycle t and low from t+1. The owner must not rely on grant in cycle t.
- Preemption:
  - A contended owner sees grant for exactly MAX_HOLD consecutive cycles.
  - The preempted port, if still requesting, is the lowest priority in the next arbitration.
  - It regains grant after the other requesters are served.
- Simultaneous events: owner drop and hold limit in the same cycle resolve as a normal release, with preempt=0.
- Requests changing on non-owner ports during OWN have no effect until the next IDLE evaluation.
- preempt is high for exactly one cycle, coincident with the first grant=0 cycle.
- MAX_HOLD=1: a contended owner gets single-cycle grants, giving strict round-robin with a 1-cycle gap.
- Reset mid-ownership: next edge all outputs 0, state IDLE, last_owner=NUM_PORTS-1, no preempt pulse.
- Invariants:
  - grant is zero or one-hot.
  - active == |grant.
  - grant_id matches grant.
  - Never grant a port whose request was low in the arbitration cycle.

Test Plan:
- Reset then request=6'b000101 steady, never dropped → grant=000001 for 8 cycles, preempt pulse, 1 idle cycle, then grant=000100 for 8 cycles, preempt, 1 idle cycle, then grant=000001 again; the cycle repeats.
- Single request[3] held 20 cycles, then dropped → grant=001000, grant_id=3 continuously for 20 cycles, preempt never asserted; grant=0 the cycle after the drop.
- After port 5 is served, request=6'b100011 → next winner is port 0, then 1, then 5, each with a 1-cycle gap (wrap-around order).
- Owner port 2 drops its request on its 8th granted cycle while port 4 is requesting → grant drops, preempt stays 0, port 4 granted after 1 idle cycle.
- MAX_HOLD=1, request=6'b111111 → grant sequence 000001, 0, 000010, 0, ... 100000, 0, 000001, with preempt on every gap.
- rst asserted while port 3 is granted, with request held at 001000 → outputs 0 on the next edge. After rst release, port 3 is granted after 1 cycle and the hold count restarts (8 cycles if contended).
